register_file_dbg: RTL
======================

REGISTER_FILE_DBG -- requirements
Module: register_file_dbg

Interface
REQ-001 Parameter DATA_W, default 32, SHALL set the register data width in bits.
REQ-002 Parameter ADDR_W, default 5, SHALL set the address width; depth is 2^ADDR_W entries.
REQ-003 Parameter ZERO_REG, default 1, SHALL hardwire entry 0 to zero when 1.
REQ-004 Parameter BYPASS, default 1, SHALL enable write-to-read forwarding when 1.
REQ-005 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-006 clk  in  1  sole clock; all state changes on its rising edge.
REQ-007 rst_n  in  1  asynchronous active-low reset.
REQ-008 i_r1, i_r2  in  ADDR_W  read addresses, ports 1 and 2.
REQ-009 d1, d2  out  DATA_W  combinational read data for i_r1 and i_r2.
REQ-010 write_register  in  ADDR_W  write address.
REQ-011 write_data  in  DATA_W  write data.
REQ-012 regwrite  in  1  write enable.
REQ-013 dump_start  in  1  single-cycle request to stream all entries out.
REQ-014 dump_valid  out  1  dump_addr/dump_data hold a valid entry.
REQ-015 dump_ready  in  1  consumer accepts the entry when high with dump_valid.
REQ-016 dump_addr  out  ADDR_W  index of the presented entry.
REQ-017 dump_data  out  DATA_W  registered snapshot of the presented entry.
REQ-018 dump_busy  out  1  high from dump acceptance until dump_done.
REQ-019 dump_done  out  1  one-cycle pulse after the last entry is accepted.

Function
REQ-020 A write SHALL occur on the rising clk edge when regwrite=1, storing write_data at write_register.
REQ-021 With ZERO_REG=1, writes to address 0 SHALL be discarded and reads of address 0 SHALL return 0, including forwarded reads.
REQ-022 With BYPASS=1, a read whose address equals write_register while regwrite=1 SHALL return write_data in the same cycle; with BYPASS=0 it SHALL return the stored value.
REQ-023 Ports 1 and 2 SHALL be independent; equal addresses on both SHALL return identical data.
REQ-024 The dump FSM SHALL have exactly the states IDLE, LOAD, SEND and DONE.
REQ-025 IDLE->LOAD SHALL occur when dump_start=1; the index SHALL be set to 0 and dump_busy SHALL rise on the next cycle.
REQ-026 In LOAD, dump_data SHALL capture the stored entry at the index (array value, not bypassed); the FSM SHALL then move to SEND.
REQ-027 In SEND, dump_valid=1 and dump_addr/dump_data SHALL stay stable until dump_valid&&dump_ready.
REQ-028 On acceptance, the FSM SHALL go to LOAD with index+1, or to DONE if the index was 2^ADDR_W-1.
REQ-029 DONE SHALL last one cycle with dump_done=1, dump_busy=0, and then return to IDLE.
REQ-030 dump_start SHALL be ignored outside IDLE.
REQ-031 The index SHALL NOT wrap: exactly 2^ADDR_W entries are emitted per dump.
REQ-032 Writes during a dump SHALL proceed normally; an entry already captured in dump_data SHALL NOT change.
REQ-033 With dump_ready held high, each entry SHALL take 2 cycles; valid for address 0 SHALL assert 2 cycles after dump_start is sampled.

Reset
REQ-034 rst_n=0 SHALL immediately clear all entries to 0, set the FSM to IDLE, and drive dump_valid, dump_busy, dump_done, dump_addr and dump_data to 0.
REQ-035 A reset during a dump SHALL abort it with no dump_done pulse.

Structure
REQ-036 The FSM state encoding and the DATA_W/ADDR_W defaults SHALL reside in a shared package, regfile_pkg.
REQ-037 The dump FSM and index counter SHALL be the sub-module regfile_dump_ctrl; storage and read/bypass logic SHALL stay in the top level.

Verification
REQ-038 Write 555 to reg 1, then 222 to reg 2; read i_r1=1, i_r2=2 -> d1=555, d2=222.
REQ-039 regwrite=1, write_register=3, write_data=0xABCD, i_r1=3 in the same cycle -> d1=0xABCD before the edge (BYPASS=1) or old value (BYPASS=0).
REQ-040 Write 777 to reg 0 with ZERO_REG=1 -> d1=0 for i_r1=0, including the write cycle.
REQ-041 Load reg k=k*10, pulse dump_start, dump_ready=1 -> 32 beats with addr 0..31 and data 0,10..310, then a single dump_done pulse, dump_busy low.
REQ-042 During a dump, hold dump_ready=0 for 5 cycles at addr 4 while writing reg 4=999 -> dump_data stays 40; a later dump shows 999.
REQ-043 Assert rst_n=0 mid-dump at addr 10 -> all outputs 0, no dump_done, a subsequent read of reg 5 returns 0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants for the debug register file: default geometry and the
// dump FSM state encoding.
package regfile_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_SEND = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

endpackage

// File: rtl/regfile_dump_ctrl.sv
// Dump sequencer: walks every register index once, snapshots each entry and
// presents it on a valid/ready stream, then pulses done.
module regfile_dump_ctrl
    import regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    input  logic              i_ready,
    input  logic [DATA_W-1:0] i_entry,
    output logic [ADDR_W-1:0] o_index,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid,
    output logic              o_busy,
    output logic              o_done,
    output logic [1:0]        o_state
);

    // Handshake: an entry transfers on a rising clk edge where o_valid && i_ready;
    // o_index/o_data are held constant from o_valid rising until that transfer.
    localparam logic [ADDR_W-1:0] LAST_INDEX = '1;

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_index;
    logic [DATA_W-1:0] r_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_index <= '0;
            r_data  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_state <= ST_LOAD;
                        r_index <= '0;
                    end
                end
                ST_LOAD: begin
                    r_data  <= i_entry;
                    r_state <= ST_SEND;
                end
                ST_SEND: begin
                    if (i_ready) begin
                        // Stop at the last index instead of wrapping to zero.
                        if (r_index == LAST_INDEX) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_index <= r_index + 1'b1;
                            r_state <= ST_LOAD;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_index = r_index;
    assign o_data  = r_data;
    assign o_valid = (r_state == ST_SEND);
    assign o_busy  = (r_state == ST_LOAD) || (r_state == ST_SEND);
    assign o_done  = (r_state == ST_DONE);
    assign o_state = r_state;

endmodule

// File: rtl/register_file_dbg.sv
// Two-read, one-write register file with optional zero register, optional
// write-to-read forwarding and a streaming debug dump of all entries.
module register_file_dbg
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] i_r1,
    input  logic [ADDR_W-1:0] i_r2,
    output logic [DATA_W-1:0] d1,
    output logic [DATA_W-1:0] d2,
    input  logic [ADDR_W-1:0] write_register,
    input  logic [DATA_W-1:0] write_data,
    input  logic              regwrite,
    input  logic              dump_start,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [ADDR_W-1:0] dump_addr,
    output logic [DATA_W-1:0] dump_data,
    output logic              dump_busy,
    output logic              dump_done,
    output logic [1:0]        o_dump_state
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic              w_wr_en;
    logic [ADDR_W-1:0] w_dump_index;
    logic [DATA_W-1:0] w_dump_entry;

    assign w_wr_en = regwrite && !((ZERO_REG != 0) && (write_register == '0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_mem[write_register] <= write_data;
        end
    end

    // The zero-register override is applied last so it also masks forwarding.
    always_comb begin
        d1 = r_mem[i_r1];
        d2 = r_mem[i_r2];
        if ((BYPASS != 0) && regwrite) begin
            if (write_register == i_r1) d1 = write_data;
            if (write_register == i_r2) d2 = write_data;
        end
        if ((ZERO_REG != 0) && (i_r1 == '0)) d1 = '0;
        if ((ZERO_REG != 0) && (i_r2 == '0)) d2 = '0;
    end

    // The dump sees the stored array value, never the forwarded write.
    assign w_dump_entry = r_mem[w_dump_index];

    regfile_dump_ctrl #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_dump_ctrl (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_start (dump_start),
        .i_ready (dump_ready),
        .i_entry (w_dump_entry),
        .o_index (w_dump_index),
        .o_data  (dump_data),
        .o_valid (dump_valid),
        .o_busy  (dump_busy),
        .o_done  (dump_done),
        .o_state (o_dump_state)
    );

    assign dump_addr = w_dump_index;

endmodule
